axi_lite_ram: RTL and testbench
===============================

AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536.
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-003 Ports, in this order; the block has one clock, and its reset is asynchronous and active-low:
  clk_i  input  1  clock, all state rising-edge
  rst_i  input  1  asynchronous active-low reset
  axi_awvalid_i  input  1  write address valid
  axi_awaddr_i  input  32  write byte address
  axi_awready_o  output  1  write address accepted
  axi_wvalid_i  input  1  write data valid
  axi_wdata_i  input  32  write data
  axi_wstrb_i  input  4  byte enables, bit n = wdata[8n+7:8n]
  axi_wready_o  output  1  write data accepted
  axi_bvalid_o  output  1  write response valid
  axi_bresp_o  output  2  write response
  axi_bready_i  input  1  write response accepted
  axi_arvalid_i  input  1  read address valid
  axi_araddr_i  input  32  read byte address
  axi_arready_o  output  1  read address accepted
  axi_rvalid_o  output  1  read data valid
  axi_rdata_o  output  32  read data
  axi_rresp_o  output  2  read response
  axi_rready_i  input  1  read data accepted

Function
REQ-004 The block is the AXI4-Lite slave for the USB bridge master port: a single-ported synchronous word RAM, one transaction in flight.
REQ-005 The word index is (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
REQ-006 AW and W are accepted independently: awready=1 while the AW holding register is empty; wready=1 while the W holding register is empty.
REQ-007 The FSM has states IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP.
REQ-008 IDLE->WR_EXEC when both write holds are full; IDLE->RD_EXEC when arvalid and arready are both high; arready=1 only in IDLE.
REQ-009 If both a write and a read are eligible in the same IDLE cycle, a one-bit last-grant flag picks the type not granted last; the flag resets to "write", so a read wins first.
REQ-010 WR_EXEC performs the RAM write for one cycle, writing only the bytes enabled by the held wstrb, clears both holds and enters WR_RESP; bvalid=1 from the next cycle.
REQ-011 WR_RESP holds bvalid/bresp stable until bready=1, then returns to IDLE; new AW/W may fill the holds during WR_RESP.
REQ-012 RD_EXEC issues the RAM read; RD_RESP asserts rvalid with rdata one cycle later, so latency is 2 cycles from AR handshake to rvalid.
REQ-013 RD_RESP holds rvalid, rdata and rresp stable until rready=1, then returns to IDLE.
REQ-014 When no response is pending, rdata=0 and resp=2'b00.
REQ-015 wstrb=4'b0000 is a legal no-op write with response OKAY.
REQ-016 A read of a word written in the immediately preceding transaction returns the new data.

Reset
REQ-017 rst_i low asynchronously clears: FSM to IDLE, both holds empty, last-grant to write, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=0, wready=0, arready=0.
REQ-018 The ready outputs rise on the first clk_i edge after rst_i deasserts; RAM contents are not reset.
REQ-019 Reset mid-transaction drops the transaction with no response; a write in WR_EXEC may or may not have been committed.

Configuration
REQ-020 Macro AXI_LITE_RAM_DECERR_EN defined: an address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) gives resp 2'b11; the write is suppressed and rdata=0.
REQ-021 Macro AXI_LITE_RAM_DECERR_EN undefined: the index wraps modulo DEPTH_WORDS and resp is always 2'b00.

Verification
REQ-022 Write 0x1000_0004 data 0xDEADBEEF strb 0xF, then read 0x1000_0004 (BASE 0x1000_0000) -> bresp 00; rvalid 2 cycles after AR; rdata 0xDEADBEEF, rresp 00.
REQ-023 W presented 3 cycles before AW, strb 0x3, data 0x0000_1234 over word 0xFFFFFFFF -> read returns 0xFFFF1234.
REQ-024 AR and AW/W all eligible in the same cycle after reset -> read served first, then write; repeat the case -> write served first.
REQ-025 bready held low 5 cycles -> bvalid/bresp stable; AR not accepted until 1 cycle after the B handshake.
REQ-026 Read of BASE+DEPTH_WORDS*4 -> with DECERR_EN: rresp 11, rdata 0, word 0 unchanged; without: returns word 0, rresp 00.
REQ-027 rst_i asserted while in RD_RESP -> rvalid drops immediately; the next read after reset completes normally.

Source files
------------

// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI4-Lite slave word RAM with one transaction in flight.
// Define AXI_LITE_RAM_DECERR_EN to answer out-of-window accesses with DECERR instead of wrapping.
module axi_lite_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        axi_awvalid_i,
    input  logic [31:0] axi_awaddr_i,
    output logic        axi_awready_o,
    input  logic        axi_wvalid_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wstrb_i,
    output logic        axi_wready_o,
    output logic        axi_bvalid_o,
    output logic [1:0]  axi_bresp_o,
    input  logic        axi_bready_i,
    input  logic        axi_arvalid_i,
    input  logic [31:0] axi_araddr_i,
    output logic        axi_arready_o,
    output logic        axi_rvalid_o,
    output logic [31:0] axi_rdata_o,
    output logic [1:0]  axi_rresp_o,
    input  logic        axi_rready_i
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          rdy_en, aw_full, w_full, last_wr, wr_err_q, rd_err_q;
    logic [31:0]   aw_addr, ar_addr, w_data, rdata_q, wr_off, rd_off, wr_mask, wr_word;
    logic [3:0]    w_strb;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_err, rd_err, wr_ok, rd_ok, contest, unused_ok;

    assign wr_off = aw_addr - BASE_ADDR;
    assign rd_off = ar_addr - BASE_ADDR;
    assign wr_idx = wr_off[AW+1:2];
    assign rd_idx = rd_off[AW+1:2];
`ifdef AXI_LITE_RAM_DECERR_EN
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    assign wr_err = wr_off >= SPAN;
    assign rd_err = rd_off >= SPAN;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif
    assign unused_ok = ^{wr_off[31:AW+2], wr_off[1:0], rd_off[31:AW+2], rd_off[1:0]};

    assign wr_ok         = aw_full & w_full;
    assign axi_awready_o = rdy_en & ~aw_full;
    assign axi_wready_o  = rdy_en & ~w_full;
    assign axi_arready_o = rdy_en & (state == IDLE) & (~wr_ok | last_wr);
    assign rd_ok         = axi_arvalid_i & axi_arready_o;
    // the grant flag only flips when a read and a write compete in the same cycle
    assign contest       = (state == IDLE) & wr_ok & axi_arvalid_i;

    assign axi_bvalid_o = state == WR_RESP;
    assign axi_bresp_o  = axi_bvalid_o ? {2{wr_err_q}} : 2'b00;
    assign axi_rvalid_o = state == RD_RESP;
    assign axi_rdata_o  = axi_rvalid_o ? rdata_q : 32'h0;
    assign axi_rresp_o  = axi_rvalid_o ? {2{rd_err_q}} : 2'b00;

    assign wr_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign wr_word = (w_data & wr_mask) | (mem[wr_idx] & ~wr_mask);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rd_ok ? RD_EXEC : wr_ok ? WR_EXEC : IDLE;
            WR_EXEC: state_nxt = WR_RESP;
            WR_RESP: state_nxt = axi_bready_i ? IDLE : WR_RESP;
            RD_EXEC: state_nxt = RD_RESP;
            RD_RESP: state_nxt = axi_rready_i ? IDLE : RD_RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            rdy_en   <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            last_wr  <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
            aw_addr  <= '0;
            ar_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            rdata_q  <= '0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (contest) last_wr <= ~last_wr;
            if (axi_awvalid_i && axi_awready_o) begin
                aw_full <= 1'b1;
                aw_addr <= axi_awaddr_i;
            end
            if (axi_wvalid_i && axi_wready_o) begin
                w_full <= 1'b1;
                w_data <= axi_wdata_i;
                w_strb <= axi_wstrb_i;
            end
            if (state == WR_EXEC) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                wr_err_q <= wr_err;
            end
            if (rd_ok) ar_addr <= axi_araddr_i;
            if (state == RD_EXEC) begin
                rd_err_q <= rd_err;
                rdata_q  <= rd_err ? 32'h0 : mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == WR_EXEC && !wr_err) mem[wr_idx] <= wr_word;
    end
endmodule

// File: tb/tb_axi_lite_ram.sv
// tb_axi_lite_ram: scoreboard bench for axi_lite_ram; expectations come from a word-array model.
module tb_axi_lite_ram;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axi_lite_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awready_o(awready),
        .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wready_o(wready),
        .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bready_i(bready),
        .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arready_o(arready),
        .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rready_i(rready)
    );

    int          n_chk = 0, n_fail = 0;
    logic [31:0] model [DEPTH];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
`ifdef AXI_LITE_RAM_DECERR_EN
        return (a - BASE) >= 32'(DEPTH * 4);
`else
        return a == 32'h0 && a != 32'h0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (is_err(a)) exp_b.push_back(2'b11);
        else begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx_of(a)][8*b +: 8] = d[8*b +: 8];
            exp_b.push_back(2'b00);
        end
    endtask

    task automatic model_rd(input logic [31:0] a);
        exp_r.push_back(is_err(a) ? {2'b11, 32'h0} : {2'b00, model[idx_of(a)]});
    endtask

    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b.size() == 0) check("b_unexpected", 34'(bresp), 34'h3_0000_0000);
            else check("bresp", 34'(bresp), 34'(exp_b.pop_front()));
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r.size() == 0) check("r_unexpected", {rresp, rdata}, 34'h3_0000_0000);
            else check("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
        end
    end

    task automatic aw_send(input logic [31:0] a);
        bit ok = 1'b0;
        awvalid = 1'b1;
        awaddr  = a;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) check("aw_timeout", 34'(ok), 34'(1));
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = wready;
        end
        if (!ok) check("w_timeout", 34'(ok), 34'(1));
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a);
        bit ok = 1'b0;
        arvalid = 1'b1;
        araddr  = a;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) check("ar_timeout", 34'(ok), 34'(1));
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = exp_b.size() == 0 && exp_r.size() == 0 && !bvalid && !rvalid;
        end
        if (!ok) check("drain_timeout", 34'(ok), 34'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        model_wr(a, d, s);
        fork
            w_send(d, s);
            begin
                if (lead > 0) begin
                    repeat (lead) @(posedge clk);
                    #1 check("w_hold_full", 34'(wready), 34'(0));
                end
                aw_send(a);
            end
        join
        drain();
    endtask

    task automatic read(input logic [31:0] a);
        int lat = 0;
        bit ok  = 1'b0;
        model_rd(a);
        ar_send(a);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            ok = rvalid;
        end
        check("rd_latency", 34'(lat), 34'(2));
        drain();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_outputs", {27'h0, awready, wready, arready, bvalid, rvalid, 2'b00}, 34'h0);
        check("rst_resp_data", {bresp, rdata}, 34'h0);
        check("rst_rresp", 34'(rresp), 34'h0);
        rst_n = 1'b1;
        check("rdy_before_edge", 34'({awready, wready, arready}), 34'(0));
        @(posedge clk);
        #1 check("rdy_after_edge", 34'({awready, wready, arready}), 34'(3'b111));
    endtask

    task automatic arb(input bit rd_first, input logic [31:0] wa, input logic [31:0] d, input logic [31:0] ra);
        bit ok = 1'b0;
        model_wr(wa, d, 4'hF);
        model_rd(ra);
        fork
            aw_send(wa);
            w_send(d, 4'hF);
        join
        fork
            ar_send(ra);
            begin
                for (int i = 0; i < 100 && !ok; i++) begin
                    @(negedge clk);
                    ok = bvalid | rvalid;
                end
                check("arb_read_first", 34'(rvalid), 34'(rd_first));
            end
        join
        drain();
    endtask

    initial begin
        bit ok;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(BASE + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, 0);
        write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        read(BASE + 32'h4);
        read(BASE + 32'h7);
        write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0);
        write(BASE + 32'h8, 32'h0000_1234, 4'h3, 3);
        read(BASE + 32'h8);
        write(BASE + 32'h8, 32'hCAFE_F00D, 4'h0, 0);
        read(BASE + 32'h8);
        read(BASE + 32'(DEPTH * 4));
        write(BASE + 32'(DEPTH * 4), 32'h5555_AAAA, 4'hF, 0);
        read(BASE);
        read(BASE - 32'h4);
        repeat (12) begin
            a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            write(a, $urandom, 4'($urandom), 0);
            read(a);
        end
        do_reset();
        arb(1'b1, BASE + 32'hC, 32'h1111_2222, BASE + 32'h4);
        arb(1'b0, BASE + 32'h10, 32'h3333_4444, BASE + 32'hC);
        bready = 1'b0;
        model_wr(BASE + 32'h14, 32'h0BAD_CAFE, 4'hF);
        model_rd(BASE + 32'h14);
        fork
            aw_send(BASE + 32'h14);
            w_send(32'h0BAD_CAFE, 4'hF);
        join
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bvalid;
        end
        @(posedge clk);
        #1 arvalid = 1'b1;
        araddr = BASE + 32'h14;
        repeat (5) begin
            @(negedge clk);
            check("b_hold", 34'({bvalid, bresp}), 34'(3'b100));
            check("ar_blocked", 34'(arready), 34'(0));
        end
        @(posedge clk);
        #1 bready = 1'b1;
        @(negedge clk);
        check("ar_blocked_at_b", 34'({bvalid, arready}), 34'(2'b10));
        @(negedge clk);
        check("ar_after_b", 34'({bvalid, arready}), 34'(2'b01));
        @(posedge clk);
        #1 arvalid = 1'b0;
        drain();
        rready = 1'b0;
        ar_send(BASE + 32'h4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rvalid;
        end
        check("rvalid_pre_rst", 34'(rvalid), 34'(1));
        #2 rst_n = 1'b0;
        #1 check("rst_in_rd_resp", {1'b0, rvalid, rdata}, 34'h0);
        rready = 1'b1;
        do_reset();
        read(BASE + 32'h4);
        check("sb_drained", 34'(exp_b.size() + exp_r.size()), 34'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
